// File: rtl/imm_pkg.sv
// Shared encodings for the immediate-extension stage: ext-op select codes,
// skid-buffer FSM states and the ISA immediate width.
package imm_pkg;

  localparam int IMM_W = 16;

  typedef enum logic [1:0] {
    EXT_SIGN   = 2'b00,
    EXT_ZERO   = 2'b01,
    EXT_LUI    = 2'b10,
    EXT_BRANCH = 2'b11
  } ext_op_e;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } state_e;

endpackage

// File: rtl/imm_ext.sv
// Combinational immediate extender: sign, zero, upper-half (LUI) placement,
// or word-aligned branch offset. Also usable by the branch target adder.
module imm_ext
  import imm_pkg::*;
#(
  parameter int size = 32
) (
  input  logic [15:0]      imm,
  input  ext_op_e          ext_op,
  output logic [size-1:0]  ext
);

  logic signed [size-1:0] sext;

  always_comb begin
    sext = {{(size-16){imm[15]}}, imm};
    unique case (ext_op)
      EXT_SIGN:   ext = sext;
      EXT_ZERO:   ext = {{(size-16){1'b0}}, imm};
      EXT_LUI:    ext = {imm, {(size-16){1'b0}}};
      EXT_BRANCH: ext = {sext[size-3:0], 2'b00};
      default:    ext = sext;
    endcase
  end

endmodule

// File: rtl/imm_extend_stage.sv
// Registered immediate-generation stage with a two-entry skid buffer
// (OUT + SKID) behind a valid/ready handshake.
module imm_extend_stage
  import imm_pkg::*;
#(
  parameter int size  = 32,
  parameter int IMM_W = imm_pkg::IMM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [1:0]       in_ext_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [size-1:0]  out_imm,
  output logic [4:0]       out_rt
);

  state_e state, state_n;

  logic            in_fire;
  logic            load_out_new;
  logic            load_out_skid;
  logic            load_skid;

  logic [size-1:0] ext_p0;
  logic [4:0]      rt_p0;
  logic [size-1:0] out_imm_p1;
  logic [4:0]      out_rt_p1;
  logic [size-1:0] skid_imm_p1;
  logic [4:0]      skid_rt_p1;

  // ---- p0: extend on entry ----
  imm_ext #(.size(size)) u_imm_ext (
    .imm    (in_instr[IMM_W-1:0]),
    .ext_op (ext_op_e'(in_ext_op)),
    .ext    (ext_p0)
  );

  assign rt_p0 = in_instr[20:16];

  // Handshake is decoded from registered state only, so out_ready never
  // reaches in_ready combinationally.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_n;
  end

  always_comb begin
    state_n       = state;
    load_out_new  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    if (flush) begin
      state_n = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            state_n      = BUSY;
            load_out_new = 1'b1;
          end
        end
        BUSY: begin
          if (in_fire && out_ready) begin
            load_out_new = 1'b1;
          end else if (in_fire) begin
            state_n   = FULL;
            load_skid = 1'b1;
          end else if (out_ready) begin
            state_n = EMPTY;
          end
        end
        FULL: begin
          if (out_ready) begin
            state_n       = BUSY;
            load_out_skid = 1'b1;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  // ---- p1: OUT register (cleared by reset) and SKID register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_imm_p1 <= '0;
      out_rt_p1  <= '0;
    end else if (load_out_new) begin
      out_imm_p1 <= ext_p0;
      out_rt_p1  <= rt_p0;
    end else if (load_out_skid) begin
      out_imm_p1 <= skid_imm_p1;
      out_rt_p1  <= skid_rt_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_imm_p1 <= ext_p0;
      skid_rt_p1  <= rt_p0;
    end
  end

  assign out_imm = out_imm_p1;
  assign out_rt  = out_rt_p1;

endmodule

// File: tb/tb_imm_extend_stage.sv
// Bench for imm_extend_stage: queue-based occupancy/order model checked every
// negedge, plus directed vectors with hand-computed literal results.
module tb_imm_extend_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [1:0]  in_ext_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [4:0]  out_rt;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] imm;
    logic [4:0]  rt;
  } entry_t;

  entry_t q[$];

  imm_extend_stage #(.size(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_ext_op (in_ext_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_rt    (out_rt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Extension rules expressed as integer arithmetic on the 16-bit field.
  function automatic logic [31:0] model_ext(input logic [1:0] op, input logic [15:0] imm);
    int u, s;
    u = int'(imm);
    s = (u >= 32768) ? u - 65536 : u;
    case (op)
      2'd0:    return 32'(s);
      2'd1:    return 32'(u);
      2'd2:    return 32'(u * 65536);
      default: return 32'(s * 4);
    endcase
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] rt, input logic [15:0] imm);
    return {11'h5a5, rt, imm};
  endfunction

  // Model: stage holds at most two entries in FIFO order.
  always @(negedge clk) begin
    bit pred_ready;
    if (!rst_n) begin
      q.delete();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_imm", 64'(out_imm), 64'd0);
      chk("rst_out_rt", 64'(out_rt), 64'd0);
    end else begin
      pred_ready = (q.size() < 2);
      chk("in_ready", 64'(in_ready), 64'(pred_ready));
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      if (q.size() != 0 && out_valid) begin
        chk("out_imm", 64'(out_imm), 64'(q[0].imm));
        chk("out_rt", 64'(out_rt), 64'(q[0].rt));
      end
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (in_valid && pred_ready)
          q.push_back('{imm: model_ext(in_ext_op, in_instr[15:0]), rt: in_instr[20:16]});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [4:0] rt, input logic [15:0] imm);
    in_valid  = v;
    in_ext_op = op;
    in_instr  = mk(rt, imm);
  endtask

  initial begin
    logic [31:0] ext_exp [4];
    ext_exp[0] = 32'hFFFF8001;
    ext_exp[1] = 32'h00008001;
    ext_exp[2] = 32'h80010000;
    ext_exp[3] = 32'hFFFE0004;

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 2'd0, 5'd0, 16'h0);
    step();
    step();
    rst_n = 1'b1;

    // One instruction per ext op, imm = 8001, visible one cycle later.
    out_ready = 1'b1;
    for (int op = 0; op < 4; op++) begin
      drive(1'b1, 2'(op), 5'(op + 1), 16'h8001);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      chk("ext_valid", 64'(out_valid), 64'd1);
      chk("ext_imm", 64'(out_imm), 64'(ext_exp[op]));
      chk("ext_rt", 64'(out_rt), 64'(op + 1));
      step();
    end

    // Back-to-back stream of 8.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'(i % 4), 5'(i), 16'(16'h1111 * (i + 1)));
      @(negedge clk);
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      if (i > 0) chk("stream_out_valid", 64'(out_valid), 64'd1);
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_last_valid", 64'(out_valid), 64'd1);
    chk("stream_last_imm", 64'(out_imm), 64'hFFFE2220);
    step();

    // Stall: A (LUI 1234) then B (ZERO 00FF) with out_ready low.
    out_ready = 1'b0;
    drive(1'b1, 2'd2, 5'd3, 16'h1234);
    step();
    drive(1'b1, 2'd1, 5'd4, 16'h00FF);
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_imm", 64'(out_imm), 64'h12340000);
      step();
    end
    out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("drain_b_imm", 64'(out_imm), 64'h000000FF);
    chk("drain_b_rt", 64'(out_rt), 64'd4);
    chk("drain_in_ready", 64'(in_ready), 64'd1);
    step();
    @(negedge clk);
    chk("drain_empty", 64'(out_valid), 64'd0);

    // Flush while FULL with a concurrent in_valid.
    out_ready = 1'b0;
    drive(1'b1, 2'd0, 5'd7, 16'h0001);
    step();
    drive(1'b1, 2'd0, 5'd8, 16'h0002);
    step();
    drive(1'b1, 2'd0, 5'd9, 16'h0003);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      step();
    end

    // Async reset pulse mid-stall, off the clock edge.
    out_ready = 1'b0;
    drive(1'b1, 2'd2, 5'd12, 16'hBEEF);
    step();
    drive(1'b1, 2'd1, 5'd13, 16'hCAFE);
    step();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_valid", 64'(out_valid), 64'd0);
    chk("areset_imm", 64'(out_imm), 64'd0);
    chk("areset_rt", 64'(out_rt), 64'd0);
    chk("areset_in_ready", 64'(in_ready), 64'd1);
    step();
    step();
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 2'd3, 5'd21, 16'h0010);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_reset_imm", 64'(out_imm), 64'h00000040);
    chk("post_reset_rt", 64'(out_rt), 64'd21);
    step();

    // Random traffic against the model.
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_ext_op = 2'($urandom_range(0, 3));
      in_instr  = $urandom;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_extend_stage.md
# imm_extend_stage

Registered immediate-generation stage between instruction decode and the ALU B-operand path. Takes the 16-bit immediate field of an accepted instruction and produces the 32-bit operand: sign-extended, zero-extended, LUI (upper-16 placement), or branch offset. Results are buffered behind a valid/ready handshake with a two-entry skid buffer, so downstream stalls never drop or duplicate an immediate.

## Interface
- `size`, 32: datapath width; must be ≥ 18.
- `IMM_W`, 16: immediate field width; fixed at 16 for this ISA.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `flush` input 1: synchronous pipeline flush; discards all buffered entries.
- `in_valid` input 1: upstream presents an instruction.
- `in_ready` output 1: stage can accept.
- `in_instr` input 32: instruction word; immediate is `in_instr[15:0]`, rt is `in_instr[20:16]`.
- `in_ext_op` input 2: extension select; encodings in Structure.
- `out_valid` output 1: `out_imm` and `out_rt` are valid.
- `out_ready` input 1: downstream accepts.
- `out_imm` output `size`: extended immediate.
- `out_rt` output 5: destination/source rt tag carried with the immediate.

## Operation
- Transfers: in_fire = `in_valid & in_ready`; out_fire = `out_valid & out_ready`.
- Extension rules, with imm = `in_instr[15:0]`:
  - SIGN: `{{(size-16){imm[15]}}, imm}`.
  - ZERO: `{{(size-16){1'b0}}, imm}`.
  - LUI: `{imm, {(size-16){1'b0}}}`.
  - BRANCH: sign-extend to `size`, then shift left 2; bits shifted out are discarded.
- The result is computed combinationally on entry and registered. No arithmetic is applied to buffered data.
- Storage: an output register (OUT) plus one skid register (SKID).
- FSM states: EMPTY (neither valid), BUSY (OUT valid, SKID empty), FULL (both valid).
  - EMPTY: in_fire → BUSY, OUT loads new data.
  - BUSY:
    - in_fire & out_ready → BUSY, OUT loads new data.
    - in_fire & !out_ready → FULL, SKID loads new data.
    - !in_fire & out_ready → EMPTY.
    - Otherwise hold.
  - FULL: out_ready → BUSY, OUT loads SKID. Otherwise hold.
- `in_ready` = (state != FULL), decoded from registered state. There is no combinational path from `out_ready` to `in_ready`.
- `out_valid` = (state != EMPTY).
- `out_imm` and `out_rt` hold stable while `out_valid & !out_ready`.
- `flush` has the highest priority. Next state is EMPTY, and an in_fire in the same cycle is discarded. Data registers need not clear.
- Reset asserted at any time, including mid-transfer: state goes to EMPTY, `out_imm` = 0, `out_rt` = 0, `out_valid` = 0, `in_ready` = 1 while `rst_n` is low. Pending entries are lost.

## Timing
- Latency: 1 cycle. An instruction accepted at edge N is visible on `out_*` after edge N, when the stage was EMPTY or drained that cycle.
- Throughput: 1 per cycle sustained while `out_ready` = 1.
- Stall tolerance: one extra accepted entry after `out_ready` falls. `in_ready` drops the cycle after SKID fills.
- Ordering: strict FIFO; SKID data always leaves after OUT data.
- Unused `in_ext_op` codes: none exist; all four are defined.
- After `rst_n` deasserts, the first in_fire can occur at the first rising edge.

## Structure
- Shared package `imm_pkg` holds:
  - ext-op encodings: EXT_SIGN = 2'b00, EXT_ZERO = 2'b01, EXT_LUI = 2'b10, EXT_BRANCH = 2'b11;
  - FSM state encodings EMPTY/BUSY/FULL (2-bit);
  - IMM_W.
- Sub-module `imm_ext`: purely combinational, with inputs imm[15:0] and ext_op, and output `size` bits. It is instantiated once, on the input side, and can be reused by the branch target adder.
- The top level contains only the FSM, the OUT and SKID registers, and the muxes.

## Test plan
- Extension, `out_ready` = 1, one instruction per op with imm = 16'h8001:
  - SIGN → 32'hFFFF8001.
  - ZERO → 32'h00008001.
  - LUI → 32'h80010000.
  - BRANCH → 32'hFFFE0004.
  - Each appears 1 cycle after acceptance.
- Back-to-back stream of 8 instructions with `out_ready` held high: 8 outputs on 8 consecutive cycles, in order, `in_ready` always 1.
- Stall: accept A (LUI 16'h1234), drop `out_ready`, accept B (ZERO 16'h00FF).
  - `in_ready` goes to 0 and `out_imm` holds 32'h12340000.
  - Raise `out_ready`: A then B (32'h000000FF) on consecutive cycles; `in_ready` returns to 1 after A leaves.
- Flush in FULL with `in_valid` = 1 in the same cycle: next cycle `out_valid` = 0, `in_ready` = 1, and no flushed or concurrent entry ever appears.
- Async reset pulse mid-stall, not aligned to `clk`: `out_valid` = 0, `out_imm` = 0, `out_rt` = 0 immediately. After release the next accepted instruction is the first output.
- Random `in_valid`/`out_ready` at 50% for 10k cycles against a scoreboard model: no loss, no duplication, order preserved, outputs stable under stall.
